imem_loadable: RTL
==================

// Module: imem_loadable
// PURPOSE
//  Parametrised instruction memory for the LEGv8 core; successor to the fixed 256x32 combinational ROM.
//  Synchronous-read fetch port plus a streaming program-load port (valid/ready) writing from word 0 upward.
//  Optional post-reset clear zeroes the array. Fetch is blocked while clearing or loading.
// PARAMETERS
//  N           32   instruction word width (bits)
//  ADDR_W      8    word-address width; DEPTH = 2**ADDR_W words
//  BOOT_CLEAR  1    1: enter CLEAR after reset and zero all words; 0: enter IDLE directly
// PORTS
//  clk            in   1         single clock, rising edge
//  reset          in   1         asynchronous, active-low reset (0 = reset asserted)
//  fetch_en       in   1         fetch request for addr this cycle
//  addr           in   ADDR_W    fetch word address
//  q              out  N         fetched instruction, registered
//  q_valid        out  1         q holds data for the request of the previous cycle
//  busy           out  1         1 in CLEAR or LOAD
//  load_start     in   1         begin a program load (honoured only in IDLE)
//  load_valid     in   1         load_data/load_last valid
//  load_data      in   N         instruction word to write
//  load_last      in   1         final word of the program
//  load_ready     out  1         1 in LOAD; a beat transfers when load_valid & load_ready
//  load_count     out  ADDR_W+1  words written by the current or most recent load
//  load_done      out  1         one-cycle pulse after the final beat
//  load_overflow  out  1         sticky: the array filled before load_last
// BEHAVIOUR
//  Reset values: q=0, q_valid=0, load_done=0, load_overflow=0, load_count=0, wptr=0.
//  After reset the state is CLEAR if BOOT_CLEAR, else IDLE. busy and load_ready decode from the state.
//  Reset mid-load or mid-clear aborts immediately. Array contents are not reset; only CLEAR zeroes them.
//  States: CLEAR, IDLE, LOAD.
//   CLEAR: write 0 to mem[wptr] and wptr++ each cycle.
//          After writing DEPTH-1: wptr=0, go to IDLE. Takes exactly DEPTH cycles.
//          fetch_en and load_start are ignored.
//   IDLE:  fetch_en=1 -> next cycle q=mem[addr], q_valid=1 (1-cycle latency).
//          fetch_en=0 -> q holds its value, q_valid=0.
//          load_start=1 -> next state LOAD; wptr=0, load_count=0, load_overflow=0.
//          fetch_en and load_start in the same cycle: the fetch is served with the old contents, then LOAD.
//   LOAD:  load_ready=1. Each beat writes mem[wptr]=load_data; wptr++ and load_count++.
//          Beat with load_last=1 -> IDLE, load_done=1 for one cycle.
//          Beat at wptr=DEPTH-1 with load_last=0 -> load_overflow=1, load_done=1, IDLE.
//          load_last=1 at wptr=DEPTH-1 is a normal completion, not an overflow.
//          load_count reaches DEPTH at most; wptr wraps to 0.
//          fetch_en is ignored: q holds, q_valid=0. load_start is ignored.
//  In all non-IDLE states q_valid=0 on the following cycle.
//  Beats offered in IDLE or CLEAR are dropped (load_ready=0).
//  Words never written since power-up hold undefined contents when BOOT_CLEAR=0.
//  Address arithmetic is unsigned and modulo DEPTH.
// STRUCTURE
//  imem_pkg: typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} imem_state_t; constant NOP_WORD = '0.
//  Sub-module imem_ram #(N, ADDR_W): 1 write port, 1 synchronous read port.
//   No reset on the array, no read-during-write handling (the FSM never reads while writing).
//  The top level holds the FSM, wptr, load_count, flags and the q/q_valid registers.
// TESTING
//  1 BOOT_CLEAR=1, release reset: busy=1 for 256 cycles, then 0. Fetches of addr 0, 0x80 and 0xFF -> q=0x00000000.
//  2 Load 3 words d29fffe1, f80b0001, d2955541 with load_last on the 3rd: load_done pulses, load_count=3.
//    Then fetch addr 1 -> q=f80b0001 with q_valid exactly one cycle later.
//  3 Toggle load_valid randomly during a 5-word load: only handshaken beats are written.
//    load_count=5, contents match, no gaps.
//  4 Stream 257 words with no load_last: load_overflow=1 after beat 256, load_count=256, beat 257 not accepted.
//    mem[0] holds beat 1. A new load_start clears load_overflow.
//  5 Assert reset (0) mid-load after 2 beats: outputs return to reset values at once.
//    State returns to CLEAR (BOOT_CLEAR=1) or IDLE (BOOT_CLEAR=0).
//  6 fetch_en and load_start in the same IDLE cycle: q shows the pre-load word with q_valid=1.
//    Fetches during LOAD give q_valid=0 and q unchanged.

Source files
------------

// File: rtl/imem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imem_pkg                                                     |
// | Description : Shared types and constants for the loadable instruction      |
// |               memory: FSM state encoding and the word written by CLEAR.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package imem_pkg;

    // Controller states. CLEAR zeroes the array, IDLE serves fetches,
    // LOAD accepts the program stream.
    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_LOAD  = 2'd2
    } imem_state_t;

    // Word written during CLEAR and shown on q before the first fetch.
    // Held wide so any word width up to 64 bits can slice it.
    localparam logic [63:0] NOP_WORD = '0;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imem_ram                                                     |
// | Description : Simple dual-port RAM, one write port and one synchronous     |
// |               read port. The array and the read register are not reset.   |
// |               Read-during-write is not handled; the controller never       |
// |               reads and writes in the same cycle.                          |
// | Ports       : clk     - rising-edge clock                                  |
// |               wr_en   - write mem[wr_addr] = wr_data                       |
// |               rd_en   - capture mem[rd_addr] into rd_data                  |
// |               rd_data - registered read data, holds when rd_en = 0         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module imem_ram #(
    parameter int N      = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [N-1:0]      wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [N-1:0]      rd_data
);

    logic [N-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : imem_ram
`default_nettype wire

// File: rtl/imem_loadable.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imem_loadable                                                |
// | Description : Parametrised LEGv8 instruction memory with a synchronous     |
// |               fetch port and a valid/ready program-load stream that        |
// |               writes from word 0 upward. Optional boot-time clear.         |
// | Ports       : clk, reset (async, active low)                               |
// |               fetch_en/addr -> q/q_valid   (1-cycle latency, IDLE only)   |
// |               busy          - controller is in CLEAR or LOAD               |
// |               load_start/load_valid/load_data/load_last -> load_ready      |
// |               load_count    - words written by the current/last load       |
// |               load_done     - one-cycle pulse after the final beat         |
// |               load_overflow - sticky, array filled before load_last        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module imem_loadable
    import imem_pkg::*;
#(
    parameter int N          = 32,
    parameter int ADDR_W     = 8,
    parameter bit BOOT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] addr,
    output logic [N-1:0]      q,
    output logic              q_valid,
    output logic              busy,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [N-1:0]      load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W:0]   load_count,
    output logic              load_done,
    output logic              load_overflow
);

    localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
    localparam logic [ADDR_W-1:0] WPTR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE     = {{ADDR_W{1'b0}}, 1'b1};
    localparam imem_state_t       RESET_STATE = BOOT_CLEAR ? S_CLEAR : S_IDLE;

    imem_state_t       state_q,         state_d;
    logic [ADDR_W-1:0] wptr_q,          wptr_d;
    logic [ADDR_W:0]   load_count_q,    load_count_d;
    logic              load_done_q,     load_done_d;
    logic              load_overflow_q, load_overflow_d;
    logic              q_valid_q,       q_valid_d;
    // Set by the first fetch after reset; until then q reads as NOP_WORD,
    // which gives q a reset value even though the RAM read register has none.
    logic              q_loaded_q,      q_loaded_d;

    logic              ram_we;
    logic [N-1:0]      ram_wdata;
    logic              ram_re;
    logic [N-1:0]      ram_rdata;

    imem_ram #(
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wptr_q),
        .wr_data (ram_wdata),
        .rd_en   (ram_re),
        .rd_addr (addr),
        .rd_data (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= RESET_STATE;
            wptr_q          <= '0;
            load_count_q    <= '0;
            load_done_q     <= 1'b0;
            load_overflow_q <= 1'b0;
            q_valid_q       <= 1'b0;
            q_loaded_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            wptr_q          <= wptr_d;
            load_count_q    <= load_count_d;
            load_done_q     <= load_done_d;
            load_overflow_q <= load_overflow_d;
            q_valid_q       <= q_valid_d;
            q_loaded_q      <= q_loaded_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        wptr_d          = wptr_q;
        load_count_d    = load_count_q;
        load_done_d     = 1'b0;
        load_overflow_d = load_overflow_q;
        q_valid_d       = 1'b0;
        ram_we          = 1'b0;
        ram_wdata       = NOP_WORD[N-1:0];
        ram_re          = 1'b0;

        case (state_q)
            S_CLEAR: begin
                // wptr wraps back to 0 naturally after the last word.
                ram_we = 1'b1;
                wptr_d = wptr_q + WPTR_ONE;
                if (wptr_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                // A fetch coinciding with load_start still reads the old
                // contents: nothing is written until the next cycle.
                if (fetch_en) begin
                    ram_re    = 1'b1;
                    q_valid_d = 1'b1;
                end
                if (load_start) begin
                    state_d         = S_LOAD;
                    wptr_d          = '0;
                    load_count_d    = '0;
                    load_overflow_d = 1'b0;
                end
            end

            S_LOAD: begin
                if (load_valid) begin
                    ram_we       = 1'b1;
                    ram_wdata    = load_data;
                    wptr_d       = wptr_q + WPTR_ONE;
                    load_count_d = load_count_q + CNT_ONE;
                    if (load_last) begin
                        load_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else if (wptr_q == LAST_ADDR) begin
                        // Array full with more program still to come.
                        load_overflow_d = 1'b1;
                        load_done_d     = 1'b1;
                        state_d         = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = RESET_STATE;
            end
        endcase

        q_loaded_d = q_loaded_q | q_valid_d;
    end

    assign q             = q_loaded_q ? ram_rdata : NOP_WORD[N-1:0];
    assign q_valid       = q_valid_q;
    assign busy          = (state_q != S_IDLE);
    assign load_ready    = (state_q == S_LOAD);
    assign load_count    = load_count_q;
    assign load_done     = load_done_q;
    assign load_overflow = load_overflow_q;

endmodule : imem_loadable
`default_nettype wire
